// File: rtl/mdac_pkg.sv
`default_nettype none
// ============================================================================
// mdac_pkg : shared constants and helpers for the MDAC lock input front end
// Revision : 1.0
// ============================================================================
package mdac_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 2;
    localparam int NUM_LINES  = 6;

    // Positions of each button inside the internal 6-bit line vector
    localparam int BTN0  = 0;
    localparam int BTN1  = 1;
    localparam int BTN2  = 2;
    localparam int BTN3  = 3;
    localparam int ENTER = 4;
    localparam int CLEAR = 5;

    function automatic logic [DIGIT_W-1:0] encode_digit(input logic [NUM_DIGITS-1:0] onehot);
        logic [DIGIT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (onehot[i]) begin
                idx = DIGIT_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdac_debounce.sv
`default_nettype none
// ============================================================================
// mdac_debounce : synchroniser plus counter-based debouncer for one button line
// Revision      : 1.0
// ============================================================================
module mdac_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic [CNT_W-1:0]       cnt;
    logic                   sync;

    assign sync = sync_chain[SYNC_STAGES-1];

    // rise is flagged on the same edge that stable goes high
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_chain <= '0;
            cnt        <= '0;
            stable     <= 1'b0;
            rise       <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
            rise       <= 1'b0;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync;
                rise   <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdac_input_conditioner.sv
`default_nettype none
// ============================================================================
// mdac_input_conditioner : debounces the six lock buttons and emits arbitrated
//                          single-cycle press events for the lock FSM
// Revision               : 1.0
// ============================================================================
module mdac_input_conditioner
    import mdac_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         btn_raw,
    input  logic               enter_raw,
    input  logic               clear_raw,
    output logic               digit_valid,
    output logic [DIGIT_W-1:0] digit_code,
    output logic               enter_pulse,
    output logic               clear_pulse,
    output logic               multi_err,
    output logic               any_held
);

    logic [NUM_LINES-1:0]  raw_lines;
    logic [NUM_LINES-1:0]  stable_lines;
    logic [NUM_LINES-1:0]  rise_lines;
    logic [NUM_DIGITS-1:0] digit_rise;
    logic [NUM_DIGITS-1:0] digit_held_other;
    logic                  single_digit;

    assign raw_lines = {clear_raw, enter_raw, btn_raw};

    generate
        for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
            mdac_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .raw    (raw_lines[i]),
                .stable (stable_lines[i]),
                .rise   (rise_lines[i])
            );
        end
    endgenerate

    // A digit rising this cycle is also stable-high, so exclude it when
    // looking for another digit that is already being held.
    assign digit_rise       = rise_lines[BTN3:BTN0];
    assign digit_held_other = stable_lines[BTN3:BTN0] & ~digit_rise;
    assign single_digit     = $onehot(digit_rise) && (digit_held_other == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            digit_valid <= 1'b0;
            digit_code  <= '0;
            enter_pulse <= 1'b0;
            clear_pulse <= 1'b0;
            multi_err   <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            digit_code  <= '0;
            enter_pulse <= 1'b0;
            clear_pulse <= 1'b0;
            multi_err   <= 1'b0;
            if (rise_lines[CLEAR]) begin
                clear_pulse <= 1'b1;
            end else if (rise_lines[ENTER]) begin
                enter_pulse <= 1'b1;
            end else if (digit_rise != '0) begin
                if (single_digit) begin
                    digit_valid <= 1'b1;
                    digit_code  <= encode_digit(digit_rise);
                end else begin
                    multi_err <= 1'b1;
                end
            end
        end
    end

    assign any_held = |stable_lines;

endmodule
`default_nettype wire
